// File: rtl/bus_rr_arbiter.sv
// Round-robin shared-bus arbiter: pops one packet per grant from driver FIFOs and pushes it to the
// receiver(s) named by its top id_w bits. Optional packet/drop counters when BUS_STATS_EN is defined.
module bus_rr_arbiter #(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 32,
  parameter int              id_w      = 8,
  parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
  parameter int              bus_gap   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [drvrs-1:0]   pndng,
  input  logic [pckg_sz-1:0] D_pop [drvrs],
  output logic [drvrs-1:0]   pop,
  input  logic [drvrs-1:0]   full,
  output logic [drvrs-1:0]   push,
  output logic [pckg_sz-1:0] D_push [drvrs],
  output logic               drop,
  output logic               busy
`ifdef BUS_STATS_EN
  ,
  output logic [31:0]        pkt_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int idx_w = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [drvrs-1:0] one_hot0 = {{(drvrs-1){1'b0}}, 1'b1};
  localparam logic [3:0] gap_last = (bus_gap > 0) ? 4'(bus_gap - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t               state_r, state_n;
  logic [idx_w-1:0]     rr_r, rr_n;
  logic [idx_w-1:0]     win_r, win_n;
  logic [drvrs-1:0]     mask_r, mask_n;
  logic [pckg_sz-1:0]   pkt_r, pkt_n;
  logic [3:0]           gap_r, gap_n;
  logic [drvrs-1:0]     pop_r, pop_n;
  logic [drvrs-1:0]     push_r, push_n;
  logic                 drop_r, drop_n;
  logic [pckg_sz-1:0]   d_push_r, d_push_n;
  logic                 busy_r;

  logic                 found_s;
  logic [idx_w-1:0]     pick_s;
  logic [idx_w-1:0]     next_rr_s;
  int                   sum_s;
  logic [pckg_sz-1:0]   head_s;
  logic [id_w-1:0]      dest_s;
  logic [drvrs-1:0]     dec_mask_s;

  // Winner search: first pending driver at or after the rr pointer, with wrap.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    sum_s   = 0;
    for (int i = 0; i < drvrs; i++) begin
      sum_s = int'(rr_r) + i;
      if (sum_s >= drvrs) begin
        sum_s = sum_s - drvrs;
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && pndng[idx_w'(sum_s)]) begin
        found_s = 1'b1;
        pick_s  = idx_w'(sum_s);
      end else begin
        found_s = found_s;
      end
    end
    if (pick_s == idx_w'(drvrs - 1)) begin
      next_rr_s = '0;
    end else begin
      next_rr_s = pick_s + idx_w'(1);
    end
  end

  // Destination decode of the granted driver's head packet; self-send is a legal unicast.
  always_comb begin
    head_s = D_pop[win_r];
    dest_s = head_s[pckg_sz-1 -: id_w];
    if (dest_s == broadcast) begin
      dec_mask_s = ~(one_hot0 << win_r);
    end else if (32'(dest_s) < 32'(drvrs)) begin
      dec_mask_s = one_hot0 << dest_s;
    end else begin
      dec_mask_s = '0;
    end
  end

  // Next-state and next-output logic; strobes default low so they pulse for one cycle.
  always_comb begin
    state_n  = state_r;
    rr_n     = rr_r;
    win_n    = win_r;
    mask_n   = mask_r;
    pkt_n    = pkt_r;
    gap_n    = gap_r;
    pop_n    = '0;
    push_n   = '0;
    drop_n   = 1'b0;
    d_push_n = d_push_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n = POP;
          win_n   = pick_s;
          rr_n    = next_rr_s;
          pop_n   = one_hot0 << pick_s;
        end else begin
          state_n = IDLE;
        end
      end
      POP: begin
        pkt_n  = head_s;
        mask_n = dec_mask_s;
        gap_n  = 4'd0;
        if (dec_mask_s == '0) begin
          drop_n  = 1'b1;
          state_n = (bus_gap > 0) ? GAP : IDLE;
        end else if ((full & dec_mask_s) == '0) begin
          // Destination already clear: push straight from the FIFO head.
          push_n   = dec_mask_s;
          d_push_n = head_s;
          state_n  = PUSH;
        end else begin
          state_n = PUSH;
        end
      end
      PUSH: begin
        if (push_r != '0) begin
          gap_n   = 4'd0;
          state_n = (bus_gap > 0) ? GAP : IDLE;
        end else if ((full & mask_r) == '0) begin
          push_n   = mask_r;
          d_push_n = pkt_r;
          state_n  = PUSH;
        end else begin
          state_n = PUSH;
        end
      end
      GAP: begin
        if (gap_r == gap_last) begin
          gap_n   = 4'd0;
          state_n = IDLE;
        end else begin
          gap_n   = gap_r + 4'd1;
          state_n = GAP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      rr_r     <= '0;
      win_r    <= '0;
      mask_r   <= '0;
      pkt_r    <= '0;
      gap_r    <= 4'd0;
      pop_r    <= '0;
      push_r   <= '0;
      drop_r   <= 1'b0;
      d_push_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      rr_r     <= rr_n;
      win_r    <= win_n;
      mask_r   <= mask_n;
      pkt_r    <= pkt_n;
      gap_r    <= gap_n;
      pop_r    <= pop_n;
      push_r   <= push_n;
      drop_r   <= drop_n;
      d_push_r <= d_push_n;
      busy_r   <= (state_n != IDLE);
    end
  end

`ifdef BUS_STATS_EN
  logic [31:0] pkt_cnt_r;
  logic [15:0] drop_cnt_r;

  // Event counters; a broadcast is one push event, both wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_cnt_r  <= 32'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (push_n != '0) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end else begin
        pkt_cnt_r <= pkt_cnt_r;
      end
      if (drop_n) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_r;
  assign drop_cnt = drop_cnt_r;
`endif

  assign pop  = pop_r;
  assign push = push_r;
  assign drop = drop_r;
  assign busy = busy_r;

  // Same packet is presented on every receiver port.
  always_comb begin
    for (int i = 0; i < drvrs; i++) begin
      D_push[i] = d_push_r;
    end
  end

endmodule
